// File: rtl/sirv_gnrl_regwr_arb_pkg.sv
// sirv_gnrl_regwr_pkg: sizing, stage record and address decode shared by the
// register-write arbiter slice (optional lock feature: SIRV_REGWR_ARB_LOCK_EN).
package sirv_gnrl_regwr_pkg;

    localparam int REGWR_NREQ  = 4;
    localparam int REGWR_DW    = 32;
    localparam int REGWR_AW    = 3;
    localparam int REGWR_DEPTH = 1 << REGWR_AW;
    localparam int REGWR_IDW   = $clog2(REGWR_NREQ);

    typedef struct packed {
        logic                 valid;
        logic [REGWR_AW-1:0]  addr;
        logic [REGWR_DW-1:0]  data;
        logic [REGWR_IDW-1:0] id;
    } regwr_stage_t;

    function automatic logic [REGWR_DEPTH-1:0] regwr_onehot(input logic [REGWR_AW-1:0] a);
        logic [REGWR_DEPTH-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sirv_gnrl_regwr_arb_if.sv
// sirv_gnrl_regwr_arb_if: requester handshake and register-bank write bundle;
// req_lock exists only when SIRV_REGWR_ARB_LOCK_EN is defined.
interface sirv_gnrl_regwr_arb_if;
    import sirv_gnrl_regwr_pkg::*;

    logic [REGWR_NREQ-1:0]          req_valid;
    logic [REGWR_NREQ-1:0]          req_ready;
    logic [REGWR_NREQ*REGWR_AW-1:0] req_addr;
    logic [REGWR_NREQ*REGWR_DW-1:0] req_data;
`ifdef SIRV_REGWR_ARB_LOCK_EN
    logic [REGWR_NREQ-1:0]          req_lock;
`endif
    logic [REGWR_DEPTH-1:0]         reg_lden;
    logic [REGWR_DW-1:0]            reg_dnxt;
    logic [REGWR_IDW-1:0]           wr_gnt_id;
    logic                           wr_busy;

    modport master (
        output req_valid, req_addr, req_data,
`ifdef SIRV_REGWR_ARB_LOCK_EN
        output req_lock,
`endif
        input  req_ready, reg_lden, reg_dnxt, wr_gnt_id, wr_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
`ifdef SIRV_REGWR_ARB_LOCK_EN
        input  req_lock,
`endif
        output req_ready, reg_lden, reg_dnxt, wr_gnt_id, wr_busy
    );

endinterface

// File: rtl/sirv_gnrl_regwr_arb_rr_pick.sv
// sirv_gnrl_rr_pick: combinational round-robin picker, first request at or after ptr wins.
module sirv_gnrl_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic found;

    assign any_o = |req_i;

    // scan from the pointer upward with wrap; the first set request takes the grant
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % N]) begin
                found = 1'b1;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sirv_gnrl_regwr_arb.sv
// sirv_gnrl_regwr_arb: round-robin write arbiter with one register stage driving a
// one-hot load-enable register bank; SIRV_REGWR_ARB_LOCK_EN adds per-requester priority lock.
module sirv_gnrl_regwr_arb
    import sirv_gnrl_regwr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sirv_gnrl_regwr_arb_if.slave  bus
);

    logic [REGWR_NREQ-1:0] gnt;
    logic [REGWR_IDW-1:0]  gnt_idx;
    logic                  req_any;
    logic                  lock_hit;
    logic [REGWR_IDW-1:0]  ptr_q, ptr_d;
    regwr_stage_t          stage_q, stage_d;

    sirv_gnrl_rr_pick #(.N(REGWR_NREQ)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (req_any)
    );

`ifdef SIRV_REGWR_ARB_LOCK_EN
    assign lock_hit = bus.req_lock[gnt_idx];
`else
    assign lock_hit = 1'b0;
`endif

    // capture the winner into the stage; a locked winner keeps top priority
    always_comb begin
        stage_d       = stage_q;
        stage_d.valid = req_any;
        if (req_any) begin
            stage_d.addr = bus.req_addr[int'(gnt_idx)*REGWR_AW +: REGWR_AW];
            stage_d.data = bus.req_data[int'(gnt_idx)*REGWR_DW +: REGWR_DW];
            stage_d.id   = gnt_idx;
        end
        ptr_d = !req_any ? ptr_q :
                lock_hit ? gnt_idx :
                (gnt_idx == REGWR_IDW'(REGWR_NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    // pointer and stage flops, cleared asynchronously so a staged write is dropped at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            stage_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.reg_lden  = stage_q.valid ? regwr_onehot(stage_q.addr) : '0;
    assign bus.reg_dnxt  = stage_q.data;
    assign bus.wr_gnt_id = stage_q.id;
    assign bus.wr_busy   = stage_q.valid;

endmodule
